// File: rtl/barcode_mimic_gen.sv
// Pulse-width barcode source: serialises an 8-bit station ID, MSB first, onto BC.
// Each bit cell starts low; a 1 has a short low (P>>2), a 0 has a long low (P-(P>>2)).
module barcode_mimic_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [21:0] period,
  input  logic        send,
  input  logic [7:0]  station_ID,
  output logic        BC,
  output logic        BC_done
);

  localparam int unsigned PW    = 22;
  localparam int unsigned IDW   = 8;
  localparam int unsigned MIN_P = 16;

  typedef enum logic {IDLE, CELL} state_t;

  state_t          state;
  logic [IDW-1:0]  sh_q;
  logic [PW-1:0]   per_q;
  logic [PW-1:0]   cnt_q;
  logic [2:0]      idx_q;

  logic [PW-1:0]   per_acc;
  logic [PW-1:0]   cnt_inc;
  logic            cell_end;

  // Low-phase length of a cell for the given period and bit value.
  function automatic logic [PW-1:0] low_time(input logic [PW-1:0] p, input logic b);
    return b ? (p >> 2) : (p - (p >> 2));
  endfunction

  always_comb begin
    per_acc  = (period < PW'(MIN_P)) ? PW'(MIN_P) : period;
    cnt_inc  = cnt_q + PW'(1);
    cell_end = (cnt_q == per_q - PW'(1));
  end

  // BC is registered from the counter value the next cycle will hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sh_q    <= '0;
      per_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      BC      <= 1'b1;
      BC_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          BC <= 1'b1;
          if (send) begin
            sh_q    <= station_ID;
            per_q   <= per_acc;
            cnt_q   <= '0;
            idx_q   <= '0;
            BC_done <= 1'b0;
            BC      <= 1'b0;
            state   <= CELL;
          end
        end
        CELL: begin
          if (cell_end) begin
            cnt_q <= '0;
            sh_q  <= {sh_q[IDW-2:0], 1'b0};
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state   <= IDLE;
              BC      <= 1'b1;
              BC_done <= 1'b1;
            end else begin
              BC <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_inc;
            BC    <= (cnt_inc < low_time(per_q, sh_q[IDW-1]));
            BC    <= !(cnt_inc < low_time(per_q, sh_q[IDW-1]));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barcode_mimic_gen.sv
// Randomised self-checking bench for barcode_mimic_gen; expected waveforms are
// derived arithmetically from (ID, period) and compared cycle by cycle.
module tb_barcode_mimic_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] period;
  logic        send;
  logic [7:0]  station_ID;
  logic        BC;
  logic        BC_done;

  int pass_cnt = 0;
  int total    = 0;

  barcode_mimic_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .period     (period),
    .send       (send),
    .station_ID (station_ID),
    .BC         (BC),
    .BC_done    (BC_done)
  );

  always #5 clk = ~clk;

  function automatic int eff_p(input int p);
    return (p < 16) ? 16 : p;
  endfunction

  function automatic int lo_of(input int p, input bit b);
    return b ? (p / 4) : (p - p / 4);
  endfunction

  // Expected BC k cycles after the accept edge (k=0 is the first cell clock).
  function automatic bit exp_bc(input logic [7:0] id, input int p, input int k);
    logic [7:0] v;
    if (k >= 8 * p) return 1'b1;
    v = id;
    return ((k % p) < lo_of(p, v[7 - k / p])) ? 1'b0 : 1'b1;
  endfunction

  // Drives one accepted frame and checks waveform, pulse widths, done timing.
  task automatic run_frame(input logic [7:0] id, input int per, input bit inject);
    int p, errs, first_k, run;
    int widths[$];
    logic [7:0] v;
    p = eff_p(per);
    errs = 0; first_k = -1; run = 0;
    @(negedge clk);
    station_ID = id; period = 22'(per); send = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 8 * p; k++) begin
      @(negedge clk);
      if (k == 0) send = 1'b0;
      if (inject && k == p)      begin send = 1'b1; station_ID = ~id; period = 22'(per + 7); end
      if (inject && k == p + 10) send = 1'b0;
      if (BC !== exp_bc(id, p, k) || (k < 8 * p && BC_done !== 1'b0)) begin
        errs++;
        if (first_k < 0) first_k = k;
      end
      if (BC === 1'b0) run++;
      else if (run > 0) begin widths.push_back(run); run = 0; end
      if (k == 8 * p) begin
        total++;
        if (BC_done !== 1'b1) $display("FAIL done_rise id=%h p=%0d got %b want 1", id, p, BC_done);
        else pass_cnt++;
      end
    end
    total++;
    if (errs != 0) $display("FAIL wave id=%h p=%0d errors=%0d first_k=%0d", id, p, errs, first_k);
    else pass_cnt++;
    total++;
    if (widths.size() != 8) $display("FAIL pulse_count id=%h got %0d want 8", id, widths.size());
    else begin
      v = id;
      errs = 0;
      for (int i = 0; i < 8; i++)
        if (widths[i] != lo_of(p, v[7 - i])) begin
          errs++;
          $display("FAIL width id=%h bit%0d got %0d want %0d", id, i, widths[i], lo_of(p, v[7 - i]));
        end
      if (errs == 0) pass_cnt++;
    end
    errs = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (BC !== 1'b1 || BC_done !== 1'b1) errs++;
    end
    total++;
    if (errs != 0) $display("FAIL idle_after id=%h errors=%0d want 0", id, errs);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    int errs;
    rst_n = 1'b0; send = 1'b0; period = '0; station_ID = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (BC !== 1'b1 || BC_done !== 1'b0) $display("FAIL reset got BC=%b done=%b want 1/0", BC, BC_done);
    else pass_cnt++;
    rst_n = 1'b1;
    errs = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (BC !== 1'b1 || BC_done !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) $display("FAIL idle_hold errors=%0d want 0", errs);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_frame(8'h10, 522, 1'b0);
  endtask

  task automatic test_all_ones_zeros();
    run_frame(8'hFF, 100, 1'b0);
    run_frame(8'h00, 100, 1'b0);
  endtask

  task automatic test_clamp_ignore();
    run_frame(8'($urandom), 5, 1'b1);
    run_frame(8'($urandom), 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_frame(8'($urandom), int'($urandom_range(0, 200)), i[0]);
  endtask

  // send held high across two frames: second accept on the first IDLE cycle.
  task automatic test_back_to_back();
    logic [7:0] ida, idb;
    int pa, pb, errs, first_k, j;
    bit eb, ed;
    ida = 8'($urandom); idb = 8'($urandom);
    pa = eff_p(int'($urandom_range(10, 60)));
    pb = eff_p(int'($urandom_range(10, 60)));
    errs = 0; first_k = -1;
    @(negedge clk);
    station_ID = ida; period = 22'(pa); send = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 8 * pa + 1 + 8 * pb; k++) begin
      @(negedge clk);
      if (k == 0) begin station_ID = idb; period = 22'(pb); end
      j = k - 8 * pa - 1;
      if (j == 0) send = 1'b0;
      if (k <= 8 * pa) begin eb = exp_bc(ida, pa, k); ed = (k == 8 * pa); end
      else begin eb = exp_bc(idb, pb, j); ed = (j >= 8 * pb); end
      if (BC !== eb || BC_done !== ed) begin
        errs++;
        if (first_k < 0) first_k = k;
      end
    end
    total++;
    if (errs != 0) $display("FAIL back_to_back errors=%0d first_k=%0d want 0", errs, first_k);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int p;
    p = 40;
    @(negedge clk);
    station_ID = 8'h5A; period = 22'(p); send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    repeat (3 * p + 5) @(negedge clk);
    total++;
    if (BC !== 1'b0) $display("FAIL mid_frame_low got BC=%b want 0", BC);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++;
    if (BC !== 1'b1 || BC_done !== 1'b0) $display("FAIL async_reset got BC=%b done=%b want 1/0", BC, BC_done);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (BC !== 1'b1 || BC_done !== 1'b0) $display("FAIL post_reset_idle got BC=%b done=%b want 1/0", BC, BC_done);
    else pass_cnt++;
    run_frame(8'hA3, 64, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones_zeros();
    test_clamp_ignore();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
